// File: rtl/mem_port_arbiter.sv
// N-port memory controller: arbitrates client word requests and serialises
// 1/2/4-byte little-endian loads/stores onto the 8-bit RAM/IO bus.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RR_MODE    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rdy,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [2*NUM_PORTS-1:0]           size,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  addr,
    input  logic [32*NUM_PORTS-1:0]          wdata,
    output logic [NUM_PORTS-1:0]             done,
    output logic [31:0]                      rdata,
    output logic                             busy,
    input  logic [7:0]                       mem_din,
    output logic [7:0]                       mem_dout,
    output logic [ADDR_WIDTH-1:0]            mem_a,
    output logic                             mem_wr
);

    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         g_q, g_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [2:0]            n_q, n_d;
    logic [2:0]            k_q, k_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] mema_q, mema_d;
    logic [7:0]            dout_q, dout_d;
    logic                  act_q;

    logic                  grant_vld;
    logic [GW-1:0]         grant_idx;
    logic [GW-1:0]         cand_idx;
    logic                  sel_we;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic                  rd_issue;
    logic [2:0]            km1;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (RR_MODE == 0) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (req[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = GW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand_idx = GW'((32'(ptr_q) + i) % NUM_PORTS);
                if (!grant_vld && req[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (GW'(i) == grant_idx) begin
                sel_we    = we[i];
                sel_size  = size[2*i +: 2];
                sel_addr  = addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                sel_wdata = wdata[32*i +: 32];
            end
        end
    end

    assign rd_issue = (state_q == S_READ) && (k_q < n_q);
    assign km1      = k_q - 3'd1;

    always_comb begin
        if (rd_issue || state_q == S_WRITE) begin
            mem_a = addr_q + ADDR_WIDTH'(k_q);
        end else begin
            mem_a = mema_q;
        end
        mem_dout = (state_q == S_WRITE) ? wdata_q[{k_q[1:0], 3'b000} +: 8] : dout_q;
        mem_wr   = (state_q == S_WRITE) && rdy && !rst;
        busy     = (state_q == S_READ) || (state_q == S_WRITE);
        rdata    = rdata_q;
        done     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            done[i] = (state_q == S_DONE) && rdy && !rst && (GW'(i) == g_q);
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mema_d  = mem_a;
        dout_d  = mem_dout;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    g_d     = grant_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    k_d     = '0;
                    case (sel_size)
                        2'd0:    n_d = 3'd1;
                        2'd1:    n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                    state_d = sel_we ? S_WRITE : S_READ;
                    if (RR_MODE != 0) begin
                        ptr_d = GW'((32'(grant_idx) + 32'd1) % NUM_PORTS);
                    end
                end
            end
            S_WRITE: begin
                k_d = k_q + 3'd1;
                if (k_q == n_q - 3'd1) begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                if (k_q == n_q) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE && grant_vld && rdy) begin
            rdata_d = '0;
        end
        // Byte k-1 is only on mem_din right after an active cycle: once paused,
        // mem_a already shows addr+k, so capture on the first paused edge and
        // skip the capture on the resume edge.
        if (state_q == S_READ && k_q != 3'd0 && act_q) begin
            rdata_d[{km1[1:0], 3'b000} +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mema_q  <= '0;
            dout_q  <= '0;
            act_q   <= 1'b0;
        end else begin
            act_q   <= rdy;
            rdata_q <= rdata_d;
            if (rdy) begin
                state_q <= state_d;
                g_q     <= g_d;
                ptr_q   <= ptr_d;
                n_q     <= n_d;
                k_q     <= k_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                mema_q  <= mema_d;
                dout_q  <= dout_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-port fixed-priority instance with
// a RAM model, and a 3-port round-robin instance for grant ordering.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [1:0]  req, we, done;
    logic [3:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [2:0]  rr_req, rr_done;
    logic [31:0] rr_rdata, rr_mem_a;
    logic        rr_busy, rr_mem_wr;
    logic [7:0]  rr_mem_dout;

    logic [7:0]  ram [0:(1<<18)-1];
    logic        pre_we = 1'b0;
    logic [17:0] pre_a = '0;
    logic [7:0]  pre_d = '0;
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    logic [31:0] aq[$];
    int          ord[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int r, at, at1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (pre_we) ram[pre_a] <= pre_d;
        if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wlog_a.push_back(mem_a);
            wlog_d.push_back(mem_dout);
        end
    end

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .RR_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req(req), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .done(done), .rdata(rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .rdy(1'b1), .req(rr_req), .we(3'b000), .size(6'b000000),
        .addr(96'd0), .wdata(96'd0), .done(rr_done), .rdata(rr_rdata), .busy(rr_busy),
        .mem_din(8'h00), .mem_dout(rr_mem_dout), .mem_a(rr_mem_a), .mem_wr(rr_mem_wr)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        we[p]            = w;
        size[2*p +: 2]   = sz;
        addr[32*p +: 32] = a;
        wdata[32*p +: 32] = d;
    endtask

    task automatic wait_done(input string tag, input int p, input int budget, output int at_cyc);
        logic ok = 1'b0;
        at_cyc = -1;
        aq.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy) aq.push_back(mem_a);
            if (done[p]) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        check_val({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; req = '0; we = '0; size = '0; addr = '0; wdata = '0;
        rr_req = '0;
        repeat (3) @(negedge clk);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_mem_wr", 64'(mem_wr), 64'd0);
        check_val("rst_mem_a", 64'(mem_a), 64'd0);
        check_val("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;

        poke(18'h00100, 8'h34);
        poke(18'h00101, 8'h12);
        poke(18'h20001, 8'h77);
        poke(18'h00200, 8'h11);
        poke(18'h00201, 8'h22);
        poke(18'h00202, 8'h33);
        poke(18'h00203, 8'h44);
        poke(18'h00301, 8'h5A);

        // T1: P0 2-byte load
        set_port(0, 1'b0, 2'd1, 32'h100, 32'h0);
        req = 2'b01; r = cyc;
        wait_done("t1", 0, 20, at);
        check_val("t1_latency", 64'(at - r), 64'd4);
        check_val("t1_rdata", 64'(rdata), 64'h1234);
        check_val("t1_done_vec", 64'(done), 64'b01);
        check_val("t1_a0", (aq.size() > 0) ? 64'(aq[0]) : '1, 64'h100);
        check_val("t1_a1", (aq.size() > 1) ? 64'(aq[1]) : '1, 64'h101);
        req = 2'b00;
        @(negedge clk);
        check_val("t1_done_pulse", 64'(done), 64'd0);

        // T2: P1 2-byte store across a 64K boundary
        wlog_a.delete(); wlog_d.delete();
        set_port(1, 1'b1, 2'd1, 32'h1FFFF, 32'hAABBCCDD);
        req = 2'b10; r = cyc;
        wait_done("t2", 1, 20, at);
        check_val("t2_latency", 64'(at - r), 64'd3);
        req = 2'b00;
        @(negedge clk);
        check_val("t2_wr_count", 64'(wlog_a.size()), 64'd2);
        check_val("t2_w0_a", (wlog_a.size() > 0) ? 64'(wlog_a[0]) : '1, 64'h1FFFF);
        check_val("t2_w0_d", (wlog_d.size() > 0) ? 64'(wlog_d[0]) : '1, 64'hDD);
        check_val("t2_w1_a", (wlog_a.size() > 1) ? 64'(wlog_a[1]) : '1, 64'h20000);
        check_val("t2_w1_d", (wlog_d.size() > 1) ? 64'(wlog_d[1]) : '1, 64'hCC);
        check_val("t2_ram_untouched", 64'(ram[18'h20001]), 64'h77);

        // T3: simultaneous requests, fixed priority
        set_port(0, 1'b0, 2'd0, 32'h100, 32'h0);
        set_port(1, 1'b0, 2'd0, 32'h101, 32'h0);
        req = 2'b11;
        wait_done("t3_p1", 1, 20, at1);
        check_val("t3_first_vec", 64'(done), 64'b10);
        check_val("t3_p1_rdata", 64'(rdata), 64'h12);
        req = 2'b01;
        wait_done("t3_p0", 0, 20, at);
        check_val("t3_gap", 64'(at - at1), 64'd4);
        check_val("t3_p0_rdata", 64'(rdata), 64'h34);
        req = 2'b00;
        @(negedge clk);

        // T4: round-robin over three continuously requesting ports
        rr_req = 3'b111;
        for (int i = 0; i < 40 && ord.size() < 6; i++) begin
            @(negedge clk);
            case (rr_done)
                3'b000: ;
                3'b001: ord.push_back(0);
                3'b010: ord.push_back(1);
                3'b100: ord.push_back(2);
                default: ord.push_back(7);
            endcase
        end
        rr_req = 3'b000;
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("t4_order%0d", i), (i < ord.size()) ? 64'(ord[i]) : 64'd99, 64'(i % 3));
        end

        // T5: 3-cycle pause while byte 1 is on the bus
        set_port(0, 1'b0, 2'd2, 32'h200, 32'h0);
        req = 2'b01; r = cyc;
        @(negedge clk);
        @(negedge clk);
        check_val("t5_pre_a", 64'(mem_a), 64'h201);
        rdy = 1'b0;
        @(negedge clk);
        check_val("t5_hold_a", 64'(mem_a), 64'h201);
        check_val("t5_hold_wr", 64'(mem_wr), 64'd0);
        @(negedge clk);
        check_val("t5_hold_a2", 64'(mem_a), 64'h201);
        @(negedge clk);
        rdy = 1'b1;
        wait_done("t5", 0, 30, at);
        check_val("t5_latency", 64'(at - r), 64'd9);
        check_val("t5_rdata", 64'(rdata), 64'h44332211);
        req = 2'b00;
        @(negedge clk);

        // T6: reset in the middle of a 4-byte store
        wlog_a.delete(); wlog_d.delete();
        set_port(1, 1'b1, 2'd2, 32'h300, 32'h0A0B0C0D);
        req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        check_val("t6_done", 64'(done), 64'd0);
        check_val("t6_busy", 64'(busy), 64'd0);
        check_val("t6_mem_wr", 64'(mem_wr), 64'd0);
        check_val("t6_mem_a", 64'(mem_a), 64'd0);
        check_val("t6_mem_dout", 64'(mem_dout), 64'd0);
        check_val("t6_wr_count", 64'(wlog_a.size()), 64'd1);
        check_val("t6_w0_d", (wlog_d.size() > 0) ? 64'(wlog_d[0]) : '1, 64'h0D);
        check_val("t6_ram_301", 64'(ram[18'h00301]), 64'h5A);
        set_port(0, 1'b0, 2'd0, 32'h300, 32'h0);
        req = 2'b01; r = cyc;
        wait_done("t6_after", 0, 20, at);
        check_val("t6_after_latency", 64'(at - r), 64'd3);
        check_val("t6_after_rdata", 64'(rdata), 64'h0D);
        req = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
